ifetch_resp_buf: RTL and testbench
==================================

// Module: ifetch_resp_buf
// PURPOSE
// - Responder side of the fetch-PC interface: accepts fetch requests (pc) from the PC stage,
//   issues them to the instruction SRAM, and returns {pc, inst} pairs in order to decode.
// - Sits between the PC/NPC stage and the IF/ID pipeline register.
// - Supports a variable-latency SRAM (addr_ok/data_ok split handshake), up to DEPTH outstanding.
// - Flush (branch/exception/ertn redirect) drops everything in flight.
// PARAMETERS
// - DEPTH   4   entries in the in-order response buffer = max outstanding+buffered fetches (power of 2, >=2)
// - ADDR_W  32  pc / SRAM address width (`ADDR_BUS_WIDTH)
// - DATA_W  32  instruction width
// PORTS
// - clk              in   1       clock, all state on posedge
// - rst              in   1       asynchronous, active-low reset
// - flush            in   1       redirect: discard all buffered and in-flight fetches
// - req_valid        in   1       PC stage presents req_pc
// - req_pc           in   ADDR_W  fetch address
// - req_ready        out  1       request accepted this cycle (req_valid & slot & ~flush & addr_ok)
// - inst_sram_req    out  1       SRAM address request
// - inst_sram_addr   out  ADDR_W  = req_pc
// - inst_sram_addr_ok in  1       SRAM accepted address
// - inst_sram_data_ok in  1       SRAM returns one word, in issue order
// - inst_sram_rdata  in   DATA_W  returned word
// - out_valid        out  1       head entry holds a returned instruction
// - out_pc           out  ADDR_W  pc of head entry
// - out_inst         out  DATA_W  instruction of head entry
// - out_ready        in   1       decode consumes head
// BEHAVIOUR
// - Reset (rst=0): pointers, occupancy, discard_cnt, all filled flags = 0; out_valid=0,
//   out_pc=out_inst=0 while empty; inst_sram_req=0, req_ready=0. Pending SRAM replies are reset with it.
// - Occupancy occ = live entries + discard_cnt; slot = (occ < DEPTH).
// - inst_sram_req = req_valid & slot & ~flush (combinational); req_ready = inst_sram_req & addr_ok.
// - Accept (req_ready=1): write req_pc to entry[tail], filled=0, tail++ (wraps mod DEPTH).
// - data_ok with discard_cnt>0: drop word, discard_cnt--. Else write rdata to entry[fill_ptr],
//   filled=1, fill_ptr++. data_ok with no outstanding fetch is illegal (assert).
// - out_valid = entry[head].filled; pc/inst driven combinationally from entry[head].
//   out_valid & out_ready: head++, entry freed. Min latency: data_ok in cycle N -> out_valid in N+1.
// - Same-cycle accept + data_ok + consume all legal; occupancy updated with net change.
// - Full (occ==DEPTH): inst_sram_req=0; draining one entry reopens next cycle (no comb. out_ready->req path).
// - flush=1 (highest priority): discard_cnt <= (issued-but-unreturned) - data_ok; all entries
//   cleared, head=tail=fill_ptr=0; out_valid forced 0 this cycle; no accept this cycle;
//   consume ignored. Flush while discard_cnt>0 accumulates correctly (counts are of SRAM replies).
// - discard_cnt width clog2(DEPTH+1); never exceeds DEPTH by the occ rule.
// STRUCTURE
// - Widths from bus.v (`ADDR_BUS, `DATA_BUS, `ADDR_BUS_WIDTH); no new shared typedefs needed.
// - One sub-module: fetch_entry_buf (DEPTH x {pc,inst,filled} storage with head/tail/fill pointers);
//   top holds handshake logic, discard counter, flush control.
// TESTING
// - Single fetch, 0-wait: pc 1c00_0000 accepted, data_ok next cycle rdata 0280_0421 ->
//   out_valid with out_pc=1c00_0000, out_inst=0280_0421 one cycle later.
// - Back-to-back 4 fetches 1c00_0000..1c00_000c, addr_ok=1, data_ok held off, out_ready=0 ->
//   5th request sees req_ready=0; release data_ok + out_ready -> 4 outputs in order.
// - Flush with 3 in flight: then 3 data_ok words dropped; new pc 1c00_0100 fetched afterwards
//   returns only that word; no stale pc ever on out_pc.
// - Flush coincident with data_ok (2 in flight): exactly 1 later reply discarded.
// - addr_ok=0 for 3 cycles with req_valid=1: req_ready=0, nothing allocated; accepted on 4th.
// - rst asserted mid-stream (2 entries valid): out_valid=0 immediately, occ=0, after release
//   pc 1c00_0000 fetch works normally.

Source files
------------

// File: rtl/ifetch_resp_buf_pkg.sv
// Shared widths and sizing helpers for the fetch response buffer.
// Default widths follow the CPU address/data bus.
package ifetch_resp_buf_pkg;

   localparam int ADDR_BUS_WIDTH = 32;
   localparam int DATA_BUS_WIDTH = 32;
   localparam int FETCH_DEPTH    = 4;

   // Width of a counter that must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width of a pointer into a depth-entry ring.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ifetch_resp_buf_if.sv
// Fetch-path bundle: PC-stage request, instruction SRAM split handshake, decode output.
// The buffer uses the slave modport; the surrounding pipeline/SRAM use master.
interface ifetch_resp_buf_if
   import ifetch_resp_buf_pkg::*;
#(
   parameter int ADDR_W = ADDR_BUS_WIDTH,
   parameter int DATA_W = DATA_BUS_WIDTH
);
   logic              flush;
   logic              req_valid;
   logic [ADDR_W-1:0] req_pc;
   logic              req_ready;
   logic              inst_sram_req;
   logic [ADDR_W-1:0] inst_sram_addr;
   logic              inst_sram_addr_ok;
   logic              inst_sram_data_ok;
   logic [DATA_W-1:0] inst_sram_rdata;
   logic              out_valid;
   logic [ADDR_W-1:0] out_pc;
   logic [DATA_W-1:0] out_inst;
   logic              out_ready;

   modport slave (
      input  flush, req_valid, req_pc,
      input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      input  out_ready,
      output req_ready, inst_sram_req, inst_sram_addr,
      output out_valid, out_pc, out_inst
   );

   modport master (
      output flush, req_valid, req_pc,
      output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      output out_ready,
      input  req_ready, inst_sram_req, inst_sram_addr,
      input  out_valid, out_pc, out_inst
   );

endinterface

// File: rtl/ifetch_resp_buf_fetch_entry_buf.sv
// In-order ring of {pc, inst, filled} entries with head (consume), tail (allocate)
// and fill (SRAM return) pointers plus live/pending counts.
module ifetch_resp_buf_fetch_entry_buf
   import ifetch_resp_buf_pkg::*;
#(
   parameter int DEPTH  = FETCH_DEPTH,
   parameter int ADDR_W = ADDR_BUS_WIDTH,
   parameter int DATA_W = DATA_BUS_WIDTH,
   localparam int CW    = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              alloc_i,
   input  logic [ADDR_W-1:0] alloc_pc_i,
   input  logic              fill_i,
   input  logic [DATA_W-1:0] fill_data_i,
   input  logic              pop_i,
   output logic [ADDR_W-1:0] head_pc_o,
   output logic [DATA_W-1:0] head_inst_o,
   output logic              head_filled_o,
   output logic [CW-1:0]     live_cnt_o,
   output logic [CW-1:0]     pend_cnt_o
);
   localparam int PW = ptr_w(DEPTH);

   logic [ADDR_W-1:0] pc_q     [DEPTH];
   logic [DATA_W-1:0] inst_q   [DEPTH];
   logic              filled_q [DEPTH];
   logic [PW-1:0]     head_q, tail_q, fill_q;
   logic [CW-1:0]     live_q, pend_q;

   logic [DEPTH-1:0]  alloc_hit, fill_hit, pop_hit;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_hit
         assign alloc_hit[gi] = alloc_i && (tail_q == PW'(gi));
         assign fill_hit[gi]  = fill_i  && (fill_q == PW'(gi));
         assign pop_hit[gi]   = pop_i   && (head_q == PW'(gi));
      end
   endgenerate

   // Freed and cleared entries are zeroed so an empty head reads back as all-zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]     <= '0;
            inst_q[i]   <= '0;
            filled_q[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (clear_i || pop_hit[i]) begin
               pc_q[i]     <= '0;
               inst_q[i]   <= '0;
               filled_q[i] <= 1'b0;
            end else begin
               if (alloc_hit[i]) begin
                  pc_q[i]     <= alloc_pc_i;
                  filled_q[i] <= 1'b0;
               end
               if (fill_hit[i]) begin
                  inst_q[i]   <= fill_data_i;
                  filled_q[i] <= 1'b1;
               end
            end
         end
      end
   end

   // Pointer widths equal log2(DEPTH), so increments wrap mod DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q <= '0;
         tail_q <= '0;
         fill_q <= '0;
         live_q <= '0;
         pend_q <= '0;
      end else if (clear_i) begin
         head_q <= '0;
         tail_q <= '0;
         fill_q <= '0;
         live_q <= '0;
         pend_q <= '0;
      end else begin
         head_q <= head_q + PW'(pop_i);
         tail_q <= tail_q + PW'(alloc_i);
         fill_q <= fill_q + PW'(fill_i);
         live_q <= live_q + CW'(alloc_i) - CW'(pop_i);
         pend_q <= pend_q + CW'(alloc_i) - CW'(fill_i);
      end
   end

   assign head_pc_o     = pc_q[head_q];
   assign head_inst_o   = inst_q[head_q];
   assign head_filled_o = filled_q[head_q];
   assign live_cnt_o    = live_q;
   assign pend_cnt_o    = pend_q;

endmodule

// File: rtl/ifetch_resp_buf.sv
// Fetch responder: issues PCs to the instruction SRAM, returns {pc, inst} in order,
// and discards replies belonging to fetches killed by a redirect flush.
module ifetch_resp_buf
   import ifetch_resp_buf_pkg::*;
#(
   parameter int DEPTH  = FETCH_DEPTH,
   parameter int ADDR_W = ADDR_BUS_WIDTH,
   parameter int DATA_W = DATA_BUS_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   ifetch_resp_buf_if.slave   bus
);
   localparam int CW = cnt_w(DEPTH);

   logic [CW-1:0] live_cnt, pend_cnt;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW:0]   occ;
   logic          slot, sram_req, accept, drop, fill, pop, head_filled;

   // Replies still owed to killed fetches hold buffer slots until they drain.
   assign occ      = {1'b0, live_cnt} + {1'b0, discard_q};
   assign slot     = occ < (CW+1)'(DEPTH);
   assign sram_req = bus.req_valid && slot && !bus.flush;
   assign accept   = sram_req && bus.inst_sram_addr_ok;
   assign drop     = bus.inst_sram_data_ok && (discard_q != '0);
   assign fill     = bus.inst_sram_data_ok && (discard_q == '0) && !bus.flush;
   assign pop      = head_filled && bus.out_ready && !bus.flush;

   assign bus.inst_sram_req  = sram_req;
   assign bus.inst_sram_addr = bus.req_pc;
   assign bus.req_ready      = accept;
   assign bus.out_valid      = head_filled && !bus.flush;

   // On flush every unreturned reply (old discards plus live pending) must be dropped.
   always_comb begin
      discard_d = discard_q;
      if (bus.flush)
         discard_d = discard_q + pend_cnt - CW'(bus.inst_sram_data_ok);
      else if (drop)
         discard_d = discard_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         discard_q <= '0;
      else
         discard_q <= discard_d;
   end

   ifetch_resp_buf_fetch_entry_buf #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_entries (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (bus.flush),
      .alloc_i       (accept),
      .alloc_pc_i    (bus.req_pc),
      .fill_i        (fill),
      .fill_data_i   (bus.inst_sram_rdata),
      .pop_i         (pop),
      .head_pc_o     (bus.out_pc),
      .head_inst_o   (bus.out_inst),
      .head_filled_o (head_filled),
      .live_cnt_o    (live_cnt),
      .pend_cnt_o    (pend_cnt)
   );

   a_no_orphan_reply: assert property (@(posedge clk) disable iff (!rst)
      bus.inst_sram_data_ok |-> ((discard_q != '0) || (pend_cnt != '0)));

endmodule

// File: tb/tb_ifetch_resp_buf.sv
// Directed bench for ifetch_resp_buf with a transaction-level scoreboard.
module tb_ifetch_resp_buf;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } pair_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ifetch_resp_buf_if ifc ();

   ifetch_resp_buf dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   pair_t       exp_q  [$];
   logic [31:0] pend_q [$];
   int          discard_m   = 0;
   int          vectors     = 0;
   int          miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      pend_q.delete();
      discard_m = 0;
   endtask

   // One clock: drive, settle, compare against the model, advance the model.
   task automatic cyc(input logic rv, input logic [31:0] pc, input logic aok,
                      input logic dok, input logic [31:0] rd, input logic ordy,
                      input logic fl);
      int    occ;
      logic  exp_req, exp_rr, exp_ov;
      pair_t hd;
      logic [31:0] p;
      ifc.req_valid         = rv;
      ifc.req_pc            = pc;
      ifc.inst_sram_addr_ok = aok;
      ifc.inst_sram_data_ok = dok;
      ifc.inst_sram_rdata   = rd;
      ifc.out_ready         = ordy;
      ifc.flush             = fl;
      #1;
      occ     = exp_q.size() + pend_q.size() + discard_m;
      exp_req = rv && !fl && (occ < 4);
      exp_rr  = exp_req && aok;
      exp_ov  = !fl && (exp_q.size() > 0);
      chk("inst_sram_req", 64'(ifc.inst_sram_req), 64'(exp_req));
      chk("req_ready", 64'(ifc.req_ready), 64'(exp_rr));
      chk("out_valid", 64'(ifc.out_valid), 64'(exp_ov));
      if (exp_q.size() > 0) begin
         hd = exp_q[0];
         chk("out_pc", 64'(ifc.out_pc), 64'(hd.pc));
         chk("out_inst", 64'(ifc.out_inst), 64'(hd.inst));
      end else if (pend_q.size() == 0) begin
         chk("out_pc_empty", 64'(ifc.out_pc), 64'h0);
         chk("out_inst_empty", 64'(ifc.out_inst), 64'h0);
      end
      if (exp_rr) chk("sram_addr", 64'(ifc.inst_sram_addr), 64'(pc));

      if (fl) begin
         discard_m = discard_m + pend_q.size() - int'(dok);
         pend_q.delete();
         exp_q.delete();
         $display("t=%0t flush, replies to discard=%0d", $time, discard_m);
      end else begin
         if (exp_ov && ordy) begin
            hd = exp_q.pop_front();
            $display("t=%0t consume pc=%h inst=%h", $time, hd.pc, hd.inst);
         end
         if (dok) begin
            if (discard_m > 0) begin
               discard_m--;
               $display("t=%0t reply %h dropped", $time, rd);
            end else if (pend_q.size() > 0) begin
               p = pend_q.pop_front();
               exp_q.push_back('{pc: p, inst: rd});
            end
         end
         if (exp_rr) begin
            pend_q.push_back(pc);
            $display("t=%0t accept pc=%h", $time, pc);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, ordy, 1'b0);
   endtask

   task automatic fetch(input logic [31:0] pc);
      cyc(1'b1, pc, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic reply(input logic [31:0] rd, input logic ordy);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, rd, ordy, 1'b0);
   endtask

   initial begin
      ifc.req_valid = 1'b0; ifc.req_pc = '0; ifc.inst_sram_addr_ok = 1'b0;
      ifc.inst_sram_data_ok = 1'b0; ifc.inst_sram_rdata = '0;
      ifc.out_ready = 1'b0; ifc.flush = 1'b0;

      // Reset state
      #2 rst = 1'b0;
      #1;
      chk("rst_out_valid", 64'(ifc.out_valid), 64'h0);
      chk("rst_out_pc", 64'(ifc.out_pc), 64'h0);
      chk("rst_out_inst", 64'(ifc.out_inst), 64'h0);
      chk("rst_sram_req", 64'(ifc.inst_sram_req), 64'h0);
      chk("rst_req_ready", 64'(ifc.req_ready), 64'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      idle(1'b0);

      // Single zero-wait fetch
      fetch(32'h1c00_0000);
      reply(32'h0280_0421, 1'b0);
      idle(1'b1);
      idle(1'b0);

      // Four back-to-back, fifth blocked, then drain in order
      for (int i = 0; i < 5; i++) fetch(32'h1c00_0000 + 32'(4 * i));
      for (int i = 0; i < 4; i++) reply(32'h0000_1000 + 32'(i), 1'b1);
      repeat (2) idle(1'b1);

      // Flush with three in flight, stale replies dropped
      for (int i = 0; i < 3; i++) fetch(32'h1c00_0020 + 32'(4 * i));
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) reply(32'hdead_beef, 1'b1);
      fetch(32'h1c00_0100);
      reply(32'h0000_0100, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Flush coincident with a reply, two in flight
      fetch(32'h1c00_0200);
      fetch(32'h1c00_0204);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hbad0_0001, 1'b0, 1'b1);
      reply(32'hbad0_0002, 1'b0);
      fetch(32'h1c00_0300);
      reply(32'h0000_abcd, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Address handshake stalls for three cycles
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h1c00_0400, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      fetch(32'h1c00_0400);
      reply(32'h0000_0400, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Reset mid-stream with two filled entries
      fetch(32'h1c00_0500);
      fetch(32'h1c00_0504);
      reply(32'h0000_0500, 1'b0);
      reply(32'h0000_0504, 1'b0);
      idle(1'b0);
      #3 rst = 1'b0;
      #1;
      model_clear();
      chk("midrst_out_valid", 64'(ifc.out_valid), 64'h0);
      chk("midrst_out_pc", 64'(ifc.out_pc), 64'h0);
      chk("midrst_out_inst", 64'(ifc.out_inst), 64'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      idle(1'b0);
      for (int i = 0; i < 4; i++) fetch(32'h1c00_0000 + 32'(4 * i));
      fetch(32'h1c00_0010);
      reply(32'h0280_0421, 1'b1);
      idle(1'b1);
      for (int i = 1; i < 4; i++) reply(32'h0000_2000 + 32'(i), 1'b1);
      repeat (2) idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
